fpu_issue_ctrl: RTL and testbench

Sequential initiator for the combinational floating-point ALU: accepts FP operation requests over a valid/ready handshake, registers operands and opcode onto the ALU inputs, waits a configurable number of cycles for the ALU path to settle, then captures the result and six exception flags into a response register held until the consumer accepts it. It sits between the instruction pipeline / test driver and the ALU. It also maintains the architectural sticky exception-flag register.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fpu_issue_ctrl_if.sv | 28 ++
 rtl/fpu_sticky_flags.sv | 24 ++
 rtl/fpu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FP issue controller: opcodes, exception flags and FSM states.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4,
    OP_RND = 3'd5,
    OP_SLT = 3'd6,
    OP_INV = 3'd7
  } fpu_op_e;

  // Bit 5 down to bit 0, matching the ALU flag bus.
  typedef struct packed {
    logic dz;
    logic qnan;
    logic snan;
    logic inexact;
    logic underflow;
    logic overflow;
  } fpu_flags_t;

  localparam int FLAG_DZ   = 5;
  localparam int FLAG_QNAN = 4;
  localparam int FLAG_SNAN = 3;
  localparam int FLAG_NX   = 2;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_OF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } fpu_state_e;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between the issuing pipeline and fpu_issue_ctrl.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [5:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  // Requester / response consumer side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

  // Issue controller side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );
endinterface

// File: rtl/fpu_sticky_flags.sv
// Architectural sticky exception flags: OR-accumulate on capture, clear on flag_clr.
// A clear coinciding with a capture leaves exactly the newly captured flags.
module fpu_sticky_flags
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  fpu_flags_t set_flags,
  input  logic       clr,
  output fpu_flags_t flags
);

  // Clear has priority over the old contents but not over a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags <= '0;
    else if (clr)
      flags <= set_en ? set_flags : '0;
    else if (set_en)
      flags <= fpu_flags_t'(flags | set_flags);
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequential issue controller for the combinational FP ALU.
// Registers a request onto the ALU inputs, holds it ALU_LATENCY cycles, captures
// result and flags into a response register held until accepted.
// Optional feature macro: FPU_STICKY_FLAGS_EN (sticky flag register + flag_clr).
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int ALU_LATENCY = 2,
  parameter int TAG_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_issue_ctrl_if.slave     bus,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  output logic [2:0]          alu_op,
  input  logic [31:0]         alu_result,
  input  logic [5:0]          alu_flags,
  input  logic                flag_clr,
  output logic [5:0]          sticky_flags
);

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

  fpu_state_e       state_q;
  logic [3:0]       cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  fpu_flags_t       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [31:0]      alu_in1_q;
  logic [31:0]      alu_in2_q;
  logic [2:0]       alu_op_q;

  logic       accept;
  logic       is_nop;
  logic       fire;
  logic       cap_en;
  fpu_flags_t cap_flags;

  // Handshake decode and the capture event feeding the sticky register.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
    is_nop    = (fpu_op_e'(bus.req_op) == OP_NOP);
    fire      = (state_q == ST_EXEC) && (cnt_q == 4'd0);
    cap_en    = fire || (accept && is_nop);
    cap_flags = fire ? fpu_flags_t'(alu_flags) : '0;
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= OP_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready rises one edge after reset release and after each response.
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            alu_in1_q   <= bus.req_a;
            alu_in2_q   <= bus.req_b;
            rsp_tag_q   <= bus.req_tag;
            if (is_nop) begin
              // ALU bypassed: operand A is the result, no exceptions.
              rsp_result_q <= bus.req_a;
              rsp_flags_q  <= '0;
              rsp_valid_q  <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              alu_op_q <= bus.req_op;
              cnt_q    <= CNT_LOAD;
              state_q  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // Capture in the last held cycle; ALU path is a multicycle path.
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= fpu_flags_t'(alu_flags);
            rsp_valid_q  <= 1'b1;
            alu_op_q     <= OP_NOP;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          alu_op_q    <= OP_NOP;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign alu_in1        = alu_in1_q;
  assign alu_in2        = alu_in2_q;
  assign alu_op         = alu_op_q;

`ifdef FPU_STICKY_FLAGS_EN
  fpu_flags_t sticky_q;

  fpu_sticky_flags u_sticky (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (cap_en),
    .set_flags (cap_flags),
    .clr       (flag_clr),
    .flags     (sticky_q)
  );

  assign sticky_flags = sticky_q;
`else
  // Feature absent: flags read as zero and the clear input has no effect.
  logic unused_sticky;
  assign unused_sticky = ^{flag_clr, cap_en, cap_flags};
  assign sticky_flags  = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl (ALU_LATENCY=2, TAG_W=4) with a scoreboard queue.
module tb_fpu_issue_ctrl;

  localparam int LAT = 2;

`ifdef FPU_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [31:0] r;
    logic [5:0]  f;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [2:0]  alu_op;
  logic [5:0]  alu_flags, sticky_flags;
  logic        flag_clr = 1'b0;
  logic [31:0] model_result = '0;
  logic [5:0]  model_flags = '0;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   seen_lat;
  logic [2:0] seen_op [16];

  fpu_issue_ctrl_if #(.TAG_W(4)) bus ();

  fpu_issue_ctrl #(.ALU_LATENCY(LAT), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags)
  );

  // ALU model: returns the programmed answer only while a real op is driven.
  assign alu_result = (alu_op != 3'd0) ? model_result : 32'hDEAD_BEEF;
  assign alu_flags  = (alu_op != 3'd0) ? model_flags  : 6'b111111;

  always #5 clk = ~clk;

  // Issue one request, push its expectation, and wait (bounded) for rsp_valid.
  // Returns at the negedge where rsp_valid is first seen; seen_lat=-1 on timeout.
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] res, input logic [5:0] flg,
                        input int clr_at);
    int n;
    exp_t e;
    model_result = res;
    model_flags  = flg;
    seen_lat     = -1;
    for (int i = 0; i < 16; i++) seen_op[i] = 3'bx;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; failures++;
      $display("FAIL handshake: req_ready=%b required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e.r = (op == 3'd0) ? a : res;
    e.f = (op == 3'd0) ? 6'b0 : flg;
    e.t = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (n <= 40) begin
      if (n < 16) seen_op[n] = alu_op;
      flag_clr = (n == clr_at);
      if (bus.rsp_valid) begin seen_lat = n; break; end
      @(negedge clk);
      n++;
    end
    flag_clr = 1'b0;
  endtask

  // Accept the current response with a one-cycle rsp_ready pulse.
  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: ready=%b valid=%b required 0/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if ({alu_in1, alu_in2, alu_op, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, sticky_flags} !== '0) begin
      failures++;
      $display("FAIL reset_outs: in1=%h in2=%h op=%0d res=%h flg=%b tag=%h st=%b required all 0",
               alu_in1, alu_in2, alu_op, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, sticky_flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_add();
    exp_t e;
    do_req(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 6'b0, 0);
    checks++;
    if (seen_lat != LAT + 1) begin
      failures++;
      $display("FAIL add_latency: got %0d required %0d", seen_lat, LAT + 1);
    end
    checks++;
    if (seen_op[1] !== 3'd1 || seen_op[2] !== 3'd1) begin
      failures++;
      $display("FAIL add_alu_op: cyc1=%0d cyc2=%0d required 1/1", seen_op[1], seen_op[2]);
    end
    checks++;
    if (alu_in1 !== 32'h3F80_0000 || alu_in2 !== 32'h4000_0000) begin
      failures++;
      $display("FAIL add_operands: got %h %h required 3f800000 40000000", alu_in1, alu_in2);
    end
    if (seen_lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_result !== e.r || bus.rsp_flags !== e.f || bus.rsp_tag !== e.t) begin
        failures++;
        $display("FAIL add_rsp: got %h/%b/%h required %h/%b/%h",
                 bus.rsp_result, bus.rsp_flags, bus.rsp_tag, e.r, e.f, e.t);
      end
      ack_rsp();
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_rsp_drop: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_nop();
    exp_t e;
    do_req(3'd0, 32'h1234_5678, 32'hCAFE_0001, 4'd5, 32'h0BAD_0BAD, 6'b111111, 0);
    checks++;
    if (seen_lat != 1) begin
      failures++;
      $display("FAIL nop_latency: got %0d required 1", seen_lat);
    end
    checks++;
    if (alu_op !== 3'd0) begin
      failures++;
      $display("FAIL nop_alu_op: got %0d required 0", alu_op);
    end
    if (seen_lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_result !== e.r || bus.rsp_flags !== e.f || bus.rsp_tag !== e.t) begin
        failures++;
        $display("FAIL nop_rsp: got %h/%b/%h required %h/%b/%h",
                 bus.rsp_result, bus.rsp_flags, bus.rsp_tag, e.r, e.f, e.t);
      end
      ack_rsp();
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int bad;
    flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
    do_req(3'd4, 32'h3F80_0000, 32'h0000_0000, 4'hA, 32'h7F80_0000, 6'b100000, 0);
    checks++;
    if (seen_lat != LAT + 1) begin
      failures++;
      $display("FAIL div_latency: got %0d required %0d", seen_lat, LAT + 1);
    end
    if (seen_lat > 0) begin
      e = sb.pop_front();
      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'h5555_5555; bus.req_tag = 4'h1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_result !== e.r ||
            bus.rsp_flags !== e.f || bus.rsp_tag !== e.t) bad++;
        @(negedge clk);
      end
      bus.req_valid = 1'b0;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL hold_stable: %0d unstable cycles, last %b/%b/%h/%b/%h required 1/0/%h/%b/%h",
                 bad, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags, bus.rsp_tag,
                 e.r, e.f, e.t);
      end
      checks++;
      if (sticky_flags !== (STICKY ? 6'b100000 : 6'b0)) begin
        failures++;
        $display("FAIL hold_sticky: got %b required %b", sticky_flags, STICKY ? 6'b100000 : 6'b0);
      end
      ack_rsp();
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL hold_no_accept: valid=%b ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_sticky();
    exp_t e;
    flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (sticky_flags !== 6'b0) begin
      failures++;
      $display("FAIL sticky_clr: got %b required 000000", sticky_flags);
    end
    do_req(3'd3, 32'h1, 32'h2, 4'd1, 32'h0000_0010, 6'b000100, 0);
    if (seen_lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_flags !== e.f || bus.rsp_result !== e.r) begin
        failures++;
        $display("FAIL sticky_rsp1: got %h/%b required %h/%b", bus.rsp_result, bus.rsp_flags, e.r, e.f);
      end
      ack_rsp();
    end
    do_req(3'd2, 32'h3, 32'h4, 4'd2, 32'h0000_0020, 6'b000001, 0);
    if (seen_lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_flags !== e.f || bus.rsp_result !== e.r) begin
        failures++;
        $display("FAIL sticky_rsp2: got %h/%b required %h/%b", bus.rsp_result, bus.rsp_flags, e.r, e.f);
      end
      ack_rsp();
    end
    checks++;
    if (sticky_flags !== (STICKY ? 6'b000101 : 6'b0)) begin
      failures++;
      $display("FAIL sticky_accum: got %b required %b", sticky_flags, STICKY ? 6'b000101 : 6'b0);
    end
    // flag_clr driven into the capture edge (end of the last EXEC cycle).
    do_req(3'd5, 32'h5, 32'h6, 4'd4, 32'h0000_0030, 6'b000010, LAT);
    if (seen_lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_flags !== e.f) begin
        failures++;
        $display("FAIL sticky_rsp3: got %b required %b", bus.rsp_flags, e.f);
      end
      checks++;
      if (sticky_flags !== (STICKY ? 6'b000010 : 6'b0)) begin
        failures++;
        $display("FAIL sticky_clr_set: got %b required %b", sticky_flags, STICKY ? 6'b000010 : 6'b0);
      end
      ack_rsp();
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int n;
    model_result = 32'h4242_4242; model_flags = 6'b010000;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 32'hAAAA_0001; bus.req_b = 32'hBBBB_0002;
    bus.req_tag = 4'd7;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);            // cycle 1 (first EXEC)
    bus.req_valid = 1'b0;
    @(negedge clk);            // cycle 2 (second EXEC)
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, alu_in1, alu_in2, alu_op, bus.rsp_result, bus.rsp_flags,
         bus.rsp_tag, sticky_flags} !== '0) begin
      failures++;
      $display("FAIL midreset_outs: rdy=%b vld=%b in1=%h in2=%h op=%0d res=%h required all 0",
               bus.req_ready, bus.rsp_valid, alu_in1, alu_in2, alu_op, bus.rsp_result);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) bad++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp: rsp_valid high %0d cycles required 0", bad);
    end
    begin
      exp_t e;
      do_req(3'd1, 32'h4000_0000, 32'h4000_0000, 4'd9, 32'h4080_0000, 6'b0, 0);
      checks++;
      if (seen_lat != LAT + 1) begin
        failures++;
        $display("FAIL midreset_next_latency: got %0d required %0d", seen_lat, LAT + 1);
      end
      if (seen_lat > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.rsp_result !== e.r || bus.rsp_tag !== e.t) begin
          failures++;
          $display("FAIL midreset_next_rsp: got %h/%h required %h/%h", bus.rsp_result, bus.rsp_tag, e.r, e.t);
        end
        ack_rsp();
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int bad;
    int got;
    exp_t e;
    model_result = 32'h3F00_0000; model_flags = 6'b000100;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 32'h1111_1111; bus.req_b = 32'h2222_2222;
    bus.req_tag = 4'hC;
    bad = 0; got = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) bad++;
        else begin
          e = sb.pop_front(); got++;
          if (bus.rsp_result !== e.r || bus.rsp_flags !== e.f || bus.rsp_tag !== e.t) bad++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc.push_back(c);
        e.r = model_result; e.f = model_flags; e.t = bus.req_tag;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid && sb.size() != 0) begin
        e = sb.pop_front(); got++;
        if (bus.rsp_result !== e.r || bus.rsp_flags !== e.f || bus.rsp_tag !== e.t) bad++;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (acc.size() < 3 || (acc[1] - acc[0]) != LAT + 2 || (acc[2] - acc[1]) != LAT + 2) begin
      failures++;
      $display("FAIL b2b_spacing: %0d accepts, first gap %0d required >=3 accepts gap %0d",
               acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1, LAT + 2);
    end
    checks++;
    if (bad != 0 || got != acc.size() || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_rsp: bad=%0d got=%0d issued=%0d left=%0d required 0/%0d/%0d/0",
               bad, got, acc.size(), sb.size(), acc.size(), acc.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_nop();
    test_hold();
    test_sticky();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
